// File: rtl/sequenciador_pc.sv
// rtl/sequenciador_pc.sv - program counter sequencer with next-PC select code and bounded return stack
module sequenciador_pc #(
    parameter logic [7:0] ENDERECO_RESET = 8'h00,
    parameter int         PROFUNDIDADE   = 4
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       Stall,
    input  logic       Desvio,
    input  logic       Salto,
    input  logic       Chamada,
    input  logic       Retorno,
    input  logic [7:0] SaidaMUX4,
    output logic [1:0] Selecao,
    output logic [7:0] PCMais1,
    output logic [7:0] TopoPilha,
    output logic [7:0] PC,
    output logic [2:0] ProfundidadePilha,
    output logic       ErroPilha
);

    localparam logic [2:0] PROF_MAX = 3'(PROFUNDIDADE);

    logic [7:0] pc_q, pc_d;
    logic [2:0] prof_q, prof_d;
    logic       erro_q, erro_d;
    logic       empilha, desempilha;

    // Eight slots so a 3-bit depth indexes the array exactly; only the
    // first PROFUNDIDADE slots are ever written.
    logic [7:0] pilha_q [0:7];

    // Select code for the external 4:1 stage, fixed priority Retorno > Chamada/Salto > Desvio
    always_comb begin
        if (Retorno) begin
            Selecao = 2'b11;
        end else if (Chamada || Salto) begin
            Selecao = 2'b10;
        end else if (Desvio) begin
            Selecao = 2'b01;
        end else begin
            Selecao = 2'b00;
        end
    end

    assign PCMais1           = pc_q + 8'd1;
    assign TopoPilha         = (prof_q == 3'd0) ? 8'h00 : pilha_q[prof_q - 3'd1];
    assign PC                = pc_q;
    assign ProfundidadePilha = prof_q;
    assign ErroPilha         = erro_q;

    // Next-state: PC follows the select stage; Retorno beats Chamada for stack effects
    always_comb begin
        pc_d       = pc_q;
        prof_d     = prof_q;
        erro_d     = erro_q;
        empilha    = 1'b0;
        desempilha = 1'b0;
        if (!Stall) begin
            pc_d = SaidaMUX4;
            if (Retorno) begin
                if (prof_q == 3'd0) begin
                    erro_d = 1'b1;
                end else begin
                    desempilha = 1'b1;
                    prof_d     = prof_q - 3'd1;
                end
            end else if (Chamada) begin
                if (prof_q == PROF_MAX) begin
                    erro_d = 1'b1;
                end else begin
                    empilha = 1'b1;
                    prof_d  = prof_q + 3'd1;
                end
            end
        end
    end

    // State registers; reset overrides stall and every control input
    always_ff @(posedge Clock) begin
        if (Reset) begin
            pc_q   <= ENDERECO_RESET;
            prof_q <= 3'd0;
            erro_q <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                pilha_q[i] <= 8'h00;
            end
        end else begin
            pc_q   <= pc_d;
            prof_q <= prof_d;
            erro_q <= erro_d;
            if (empilha) begin
                pilha_q[prof_q] <= PCMais1;
            end
            if (desempilha) begin
                // Cleared on pop so stale return addresses never resurface
                pilha_q[prof_q - 3'd1] <= 8'h00;
            end
        end
    end

endmodule
